multicycle_control: RTL

//  Multi-cycle control FSM for the Lapido core; successor to the single-state decoder.
//  - Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives datapath control.
//  - Waits on a memory handshake, with a bounded wait.
//  - Flags illegal classes and memory timeouts.
//  - Sits between the instruction register / PC logic and the ALU / register file / data memory.

---
 rtl/multicycle_control_pkg.sv | 37 +++
 rtl/multicycle_control_instr_class_decode.sv | 61 ++++++
 rtl/multicycle_control.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_pkg.sv
// ----------------------------------------------------------------------------
// lapido_ctrl_pkg
// Shared definitions for the Lapido multi-cycle control unit: the state
// encodings seen on state_o, the instruction class codes in the top three
// instruction bits, and the two fixed ALU operations the controller issues
// on its own (address add for memory, compare-subtract for branches).
// ----------------------------------------------------------------------------
package lapido_ctrl_pkg;

   localparam logic [2:0] FETCH  = 3'd0;
   localparam logic [2:0] DECODE = 3'd1;
   localparam logic [2:0] EXEC   = 3'd2;
   localparam logic [2:0] MEM    = 3'd3;
   localparam logic [2:0] WB     = 3'd4;

   typedef enum logic [2:0] {
      ST_FETCH  = FETCH,
      ST_DECODE = DECODE,
      ST_EXEC   = EXEC,
      ST_MEM    = MEM,
      ST_WB     = WB
   } state_t;

   localparam logic [2:0] CLS_ALU = 3'b100;
   localparam logic [2:0] CLS_MEM = 3'b001;
   localparam logic [2:0] CLS_BR  = 3'b010;

   localparam int unsigned ALUOP_ADD = 0;
   localparam int unsigned ALUOP_SUB = 1;

   // Only three of the eight class codes are implemented; everything else
   // is reported as illegal by the controller.
   function automatic logic is_legal_class(input logic [2:0] cls);
      return (cls == CLS_ALU) || (cls == CLS_MEM) || (cls == CLS_BR);
   endfunction

endpackage

// File: rtl/multicycle_control_instr_class_decode.sv
// ----------------------------------------------------------------------------
// instr_class_decode
// Purely combinational decode of the instruction word into the fields the
// control FSM needs. The FSM registers whatever it uses from here.
// Ports:
//   instruction  in   INSTR_W  current instruction word
//   cls          out  3        class field (top three bits)
//   legal        out  1        class is one of ALU / MEM / BRANCH
//   is_store     out  1        load/store select bit (1 = store)
//   alu_op       out  ALUOP_W  ALU operation to issue in EXEC
//   alu_src      out  1        ALU B operand is the immediate (MEM class)
// ----------------------------------------------------------------------------
module instr_class_decode
   import lapido_ctrl_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int ALUOP_W = 5
) (
   input  logic [INSTR_W-1:0] instruction,
   output logic [2:0]         cls,
   output logic               legal,
   output logic               is_store,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               alu_src
);

   // Most instruction bits belong to the datapath (register indices,
   // immediates); they are folded here only to mark them as intentionally
   // unused by the controller.
   logic unused_bits;
   assign unused_bits = ^instruction;

   // ALU class takes its operation straight from the instruction; memory
   // accesses compute base+offset, branches compare by subtraction.
   always_comb begin
      cls      = instruction[INSTR_W-1 -: 3];
      legal    = is_legal_class(cls);
      is_store = instruction[INSTR_W-8];
      alu_op   = '0;
      alu_src  = 1'b0;
      case (cls)
         CLS_ALU: begin
            alu_op  = instruction[INSTR_W-4 -: ALUOP_W];
            alu_src = 1'b0;
         end
         CLS_MEM: begin
            alu_op  = ALUOP_W'(ALUOP_ADD);
            alu_src = 1'b1;
         end
         CLS_BR: begin
            alu_op  = ALUOP_W'(ALUOP_SUB);
            alu_src = 1'b0;
         end
         default: begin
            alu_op  = '0;
            alu_src = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// ----------------------------------------------------------------------------
// multicycle_control
// Multi-cycle control FSM of the Lapido core. Walks each instruction through
// FETCH / DECODE / EXEC / MEM / WB and drives the datapath strobes. Every
// output is a register loaded on the same edge that enters the state it
// belongs to, so a strobe is high for exactly the cycle(s) spent in that
// state. The two exceptions follow from when their inputs are sampled:
// ir_load/pc_enable appear in the cycle after FETCH accepts an instruction,
// and branch appears in the cycle after EXEC samples alu_zero.
// Ports:
//   clock        in   1        system clock, rising edge
//   reset        in   1        asynchronous, active-high
//   instr_valid  in   1        fetched instruction present
//   instruction  in   INSTR_W  current instruction word
//   alu_zero     in   1        ALU zero flag (branch compare result)
//   mem_ack      in   1        data memory completed request
//   ir_load      out  1        load instruction register
//   pc_enable    out  1        advance PC
//   branch       out  1        take branch
//   mem_read     out  1        data memory read request
//   mem_write    out  1        data memory write request
//   mem_to_reg   out  1        writeback selects memory data
//   alu_src      out  1        ALU B operand is the immediate
//   alu_op       out  ALUOP_W  ALU operation
//   reg_write    out  1        register file write strobe
//   illegal      out  1        sticky: unknown class decoded
//   timeout      out  1        sticky: memory did not acknowledge in time
//   state_o      out  3        current state encoding
// ----------------------------------------------------------------------------
module multicycle_control
   import lapido_ctrl_pkg::*;
#(
   parameter int INSTR_W  = 32,
   parameter int ALUOP_W  = 5,
   parameter int WAIT_MAX = 15
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               instr_valid,
   input  logic [INSTR_W-1:0] instruction,
   input  logic               alu_zero,
   input  logic               mem_ack,
   output logic               ir_load,
   output logic               pc_enable,
   output logic               branch,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               alu_src,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               reg_write,
   output logic               illegal,
   output logic               timeout,
   output logic [2:0]         state_o
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);
   // The counter holds the number of MEM cycles already spent without an
   // ack, so the cycle seeing this value is the last one allowed.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

   state_t               state, state_nxt;
   logic [2:0]           cls_q, cls_nxt;
   logic                 store_q, store_nxt;
   logic [CNT_W-1:0]     wait_cnt, wait_cnt_nxt;

   logic                 ir_load_nxt, pc_enable_nxt, branch_nxt;
   logic                 mem_read_nxt, mem_write_nxt, mem_to_reg_nxt;
   logic                 alu_src_nxt, reg_write_nxt;
   logic [ALUOP_W-1:0]   alu_op_nxt;
   logic                 illegal_nxt, timeout_nxt;

   logic [2:0]           dec_cls;
   logic                 dec_legal, dec_store, dec_alu_src;
   logic [ALUOP_W-1:0]   dec_alu_op;

   instr_class_decode #(
      .INSTR_W (INSTR_W),
      .ALUOP_W (ALUOP_W)
   ) u_decode (
      .instruction (instruction),
      .cls         (dec_cls),
      .legal       (dec_legal),
      .is_store    (dec_store),
      .alu_op      (dec_alu_op),
      .alu_src     (dec_alu_src)
   );

   assign state_o = state;

   // State, latched decode and output registers. Reset clears everything
   // asynchronously, which also drops a memory request that is in flight.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= ST_FETCH;
         cls_q      <= '0;
         store_q    <= 1'b0;
         wait_cnt   <= '0;
         ir_load    <= 1'b0;
         pc_enable  <= 1'b0;
         branch     <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_to_reg <= 1'b0;
         alu_src    <= 1'b0;
         alu_op     <= '0;
         reg_write  <= 1'b0;
         illegal    <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cls_q      <= cls_nxt;
         store_q    <= store_nxt;
         wait_cnt   <= wait_cnt_nxt;
         ir_load    <= ir_load_nxt;
         pc_enable  <= pc_enable_nxt;
         branch     <= branch_nxt;
         mem_read   <= mem_read_nxt;
         mem_write  <= mem_write_nxt;
         mem_to_reg <= mem_to_reg_nxt;
         alu_src    <= alu_src_nxt;
         alu_op     <= alu_op_nxt;
         reg_write  <= reg_write_nxt;
         illegal    <= illegal_nxt;
         timeout    <= timeout_nxt;
      end
   end

   // Next state plus the output values for the state being entered. Strobes
   // default low so each one lasts only as long as the state that sets it;
   // the two error flags default to their current value so they stick.
   always_comb begin
      state_nxt      = state;
      cls_nxt        = cls_q;
      store_nxt      = store_q;
      wait_cnt_nxt   = '0;
      ir_load_nxt    = 1'b0;
      pc_enable_nxt  = 1'b0;
      branch_nxt     = 1'b0;
      mem_read_nxt   = 1'b0;
      mem_write_nxt  = 1'b0;
      mem_to_reg_nxt = 1'b0;
      alu_src_nxt    = 1'b0;
      alu_op_nxt     = '0;
      reg_write_nxt  = 1'b0;
      illegal_nxt    = illegal;
      timeout_nxt    = timeout;

      case (state)
         ST_FETCH: begin
            if (instr_valid) begin
               ir_load_nxt   = 1'b1;
               pc_enable_nxt = 1'b1;
               state_nxt     = ST_DECODE;
            end
         end

         ST_DECODE: begin
            cls_nxt   = dec_cls;
            store_nxt = dec_store;
            if (!dec_legal) begin
               illegal_nxt = 1'b1;
               state_nxt   = ST_FETCH;
            end else begin
               alu_op_nxt  = dec_alu_op;
               alu_src_nxt = dec_alu_src;
               state_nxt   = ST_EXEC;
            end
         end

         ST_EXEC: begin
            case (cls_q)
               CLS_ALU: begin
                  reg_write_nxt = 1'b1;
                  state_nxt     = ST_WB;
               end
               CLS_MEM: begin
                  mem_read_nxt  = !store_q;
                  mem_write_nxt = store_q;
                  state_nxt     = ST_MEM;
               end
               default: begin
                  branch_nxt = alu_zero;
                  state_nxt  = ST_FETCH;
               end
            endcase
         end

         // An ack in the last allowed cycle is still honoured because it is
         // tested before the limit.
         ST_MEM: begin
            if (mem_ack) begin
               if (store_q) begin
                  state_nxt = ST_FETCH;
               end else begin
                  mem_to_reg_nxt = 1'b1;
                  reg_write_nxt  = 1'b1;
                  state_nxt      = ST_WB;
               end
            end else if (wait_cnt == WAIT_LAST) begin
               timeout_nxt = 1'b1;
               state_nxt   = ST_FETCH;
            end else begin
               mem_read_nxt  = !store_q;
               mem_write_nxt = store_q;
               wait_cnt_nxt  = wait_cnt + 1'b1;
            end
         end

         ST_WB: begin
            state_nxt = ST_FETCH;
         end

         default: begin
            state_nxt = ST_FETCH;
         end
      endcase
   end

endmodule
